// File: rtl/ps2_key_translator_if.sv
// Byte-stream input and translated-character output handshake of the PS/2 key translator.
//   in_valid/in_data   : one raw PS/2 set-2 byte per valid cycle (toward translator)
//   out_valid/out_ready: FIFO head handshake (entry accepted when both are high)
//   out_ascii/out_mods : head entry character and {ctrl, alt} captured at make time
interface ps2_key_translator_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ascii;
  logic [1:0] out_mods;

  // Translator side
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_ascii, out_mods
  );

  // Byte source / character consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_ascii, out_mods
  );
endinterface

// File: rtl/ps2_key_translator.sv
// PS/2 set-2 scancode stream to ASCII translator.
// Decodes make/break events (E0/F0/E1 prefixes), tracks shift/ctrl/alt, caps lock and a
// language layer, looks up printable makes in an external 1-cycle-latency ROM and queues
// non-zero results in a first-word-fall-through FIFO.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : byte input and FIFO output handshake (slave side)
//   rom_addr   : {lang, shift_eff, ext, code} of the latest translated make
//   rom_data   : ROM character, valid one cycle after rom_addr; 8'h00 = no character
//   caps_lock  : caps lock state
//   lang       : current language layer
//   shift_eff  : shift held XOR caps lock
//   overflow   : one-cycle pulse when a character is dropped on a full FIFO
module ps2_key_translator #(
  parameter int unsigned LANG_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  LANG_KEY   = 8'h0E
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_key_translator_if.slave   bus,
  output logic [LANG_BITS+9:0]  rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  caps_lock,
  output logic [LANG_BITS-1:0]  lang,
  output logic                  shift_eff,
  output logic                  overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  typedef struct packed {
    logic [1:0] mods;
    logic [7:0] ascii;
  } entry_t;

  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_cnt_nxt;
  logic       ev_make_c, ev_brk_c, ev_ext_c;

  // Decoder state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  // Decoder next state and make/break event strobes
  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    ev_make_c    = 1'b0;
    ev_brk_c     = 1'b0;
    ev_ext_c     = 1'b0;
    if (bus.in_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.in_data == CODE_EXT) begin
            state_nxt = S_EXT;
          end else if (bus.in_data == CODE_BRK) begin
            state_nxt = S_BRK;
          end else if (bus.in_data == CODE_PAUSE) begin
            // Pause is E1 followed by seven more bytes and produces no event
            state_nxt    = S_SKIP;
            skip_cnt_nxt = 3'd7;
          end else begin
            ev_make_c = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.in_data == CODE_BRK) begin
            state_nxt = S_EXT_BRK;
          end else if (bus.in_data != CODE_EXT) begin
            ev_make_c = 1'b1;
            ev_ext_c  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          ev_brk_c  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          ev_brk_c  = 1'b1;
          ev_ext_c  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_SKIP: begin
          skip_cnt_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Key classification of the byte that terminates an event
  logic is_lshift_c, is_rshift_c, is_ctrl_c, is_alt_c, is_caps_c, is_lang_c, is_mod_c;
  logic translate_c;

  assign is_lshift_c = !ev_ext_c && (bus.in_data == CODE_LSHIFT);
  assign is_rshift_c = !ev_ext_c && (bus.in_data == CODE_RSHIFT);
  assign is_ctrl_c   = (bus.in_data == CODE_CTRL);
  assign is_alt_c    = (bus.in_data == CODE_ALT);
  assign is_caps_c   = !ev_ext_c && (bus.in_data == CODE_CAPS);
  assign is_lang_c   = !ev_ext_c && (bus.in_data == LANG_KEY);
  assign is_mod_c    = is_lshift_c | is_rshift_c | is_ctrl_c | is_alt_c | is_caps_c | is_lang_c;
  assign translate_c = ev_make_c && !is_mod_c;

  logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
  logic caps_held, lang_held;

  // Modifier, caps lock and language layer tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      ctrl_l    <= 1'b0;
      ctrl_r    <= 1'b0;
      alt_l     <= 1'b0;
      alt_r     <= 1'b0;
      caps_held <= 1'b0;
      lang_held <= 1'b0;
      caps_lock <= 1'b0;
      lang      <= '0;
    end else if (ev_make_c || ev_brk_c) begin
      if (is_lshift_c) shift_l <= ev_make_c;
      if (is_rshift_c) shift_r <= ev_make_c;
      if (is_ctrl_c) begin
        if (ev_ext_c) ctrl_r <= ev_make_c;
        else          ctrl_l <= ev_make_c;
      end
      if (is_alt_c) begin
        if (ev_ext_c) alt_r <= ev_make_c;
        else          alt_l <= ev_make_c;
      end
      // Held flags swallow typematic repeats so only the first make toggles
      if (is_caps_c) begin
        caps_held <= ev_make_c;
        if (ev_make_c && !caps_held) caps_lock <= ~caps_lock;
      end
      if (is_lang_c) begin
        lang_held <= ev_make_c;
        if (ev_make_c && !lang_held) lang <= lang + LANG_BITS'(1);
      end
    end
  end

  assign shift_eff = (shift_l | shift_r) ^ caps_lock;

  logic       pend1, pend2;
  logic [1:0] mods1, mods2;

  // ROM lookup pipeline: address in the event cycle, data sampled one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend1    <= 1'b0;
      pend2    <= 1'b0;
      mods1    <= 2'b00;
      mods2    <= 2'b00;
      rom_addr <= '0;
    end else begin
      pend1 <= translate_c;
      pend2 <= pend1;
      mods2 <= mods1;
      if (translate_c) begin
        rom_addr <= {lang, shift_eff, ev_ext_c, bus.in_data};
        mods1    <= {ctrl_l | ctrl_r, alt_l | alt_r};
      end
    end
  end

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_c, pop_c, full_c, wr_en_c;

  assign push_c  = pend2 && (rom_data != 8'h00);
  assign pop_c   = bus.out_valid && bus.out_ready;
  assign full_c  = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_en_c = push_c && (!full_c || pop_c);

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= '{mods: mods2, ascii: rom_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count + CW'(wr_en_c) - CW'(pop_c);
      overflow <= push_c && !wr_en_c;
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_ascii = mem[rd_ptr].ascii;
  assign bus.out_mods  = mem[rd_ptr].mods;

endmodule

// File: tb/tb_ps2_key_translator.sv
// Bench for ps2_key_translator: directed scenarios followed by randomized byte streams,
// all checked every cycle against a transaction-level model of the key translator.
module tb_ps2_key_translator;

  localparam int unsigned LANG_BITS  = 1;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [7:0]  LANG_KEY   = 8'h0E;
  localparam int          NUM_LANGS  = 1 << LANG_BITS;
  localparam int          RAW        = LANG_BITS + 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [RAW-1:0] rom_addr;
  logic [7:0]     rom_data;
  logic           caps_lock;
  logic [LANG_BITS-1:0] lang;
  logic           shift_eff;
  logic           overflow;

  ps2_key_translator_if bus_if ();

  ps2_key_translator #(
    .LANG_BITS (LANG_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LANG_KEY  (LANG_KEY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .caps_lock(caps_lock),
    .lang     (lang),
    .shift_eff(shift_eff),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Character table: codes ending in 3'b111 have no character
  function automatic logic [7:0] rom_fn(input logic [RAW-1:0] a);
    logic [7:0] c;
    int         k;
    c = a[7:0];
    if (c[2:0] == 3'b111) return 8'h00;
    if (a[RAW-1:8] == '0 && c == 8'h1C) return 8'h61;
    k = (int'(c) * 3 + int'(a[RAW-1:8]) * 29) % 95;
    return 8'(32 + k);
  endfunction

  // Synchronous ROM, one cycle of latency
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct packed {
    logic [1:0] mods;
    logic [7:0] ascii;
    int         due;
  } infl_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_pops = 0;
  logic rdy_g = 1'b0;

  bit             held [2][256];
  logic           m_caps;
  logic [LANG_BITS-1:0] m_lang;
  logic           m_e0, m_f0;
  int             m_skip;
  logic [RAW-1:0] m_addr;
  logic           m_ovf;
  infl_t          infl [$];
  logic [9:0]     expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_shift_eff();
    return (held[0][8'h12] | held[0][8'h59]) ^ m_caps;
  endfunction

  function automatic void model_reset();
    foreach (held[i, j]) held[i][j] = 1'b0;
    m_caps = 1'b0;
    m_lang = '0;
    m_e0   = 1'b0;
    m_f0   = 1'b0;
    m_skip = 0;
    m_addr = '0;
    m_ovf  = 1'b0;
    infl.delete();
    expq.delete();
  endfunction

  // One decoded key event applied to the keyboard state
  function automatic void model_event(input bit mk, input bit ext, input logic [7:0] code);
    bit         is_mod;
    logic [7:0] a;
    is_mod = (!ext && (code == 8'h12 || code == 8'h59 || code == 8'h58 || code == LANG_KEY)) ||
             code == 8'h14 || code == 8'h11;
    if (mk) begin
      if (!is_mod) begin
        m_addr = {m_lang, m_shift_eff(), ext, code};
        a = rom_fn(m_addr);
        if (a != 8'h00)
          infl.push_back('{mods: {held[0][8'h14] | held[1][8'h14], held[0][8'h11] | held[1][8'h11]},
                           ascii: a, due: cyc + 2});
      end
      if (!ext && code == 8'h58 && !held[0][8'h58]) m_caps = ~m_caps;
      if (!ext && code == LANG_KEY && !held[0][LANG_KEY])
        m_lang = LANG_BITS'((int'(m_lang) + 1) % NUM_LANGS);
      held[ext][code] = 1'b1;
    end else begin
      held[ext][code] = 1'b0;
    end
  endfunction

  // Effect of one clock edge: pop, scheduled push, then the byte on the bus
  function automatic void model_edge(input logic v, input logic [7:0] d, input logic rdy);
    m_ovf = 1'b0;
    if (expq.size() > 0 && rdy) begin
      void'(expq.pop_front());
      n_pops++;
    end
    if (infl.size() > 0 && infl[0].due == cyc) begin
      if (expq.size() < int'(FIFO_DEPTH)) expq.push_back({infl[0].mods, infl[0].ascii});
      else m_ovf = 1'b1;
      void'(infl.pop_front());
    end
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (!m_e0 && !m_f0) begin
        if (d == 8'hE0) m_e0 = 1'b1;
        else if (d == 8'hF0) m_f0 = 1'b1;
        else if (d == 8'hE1) m_skip = 7;
        else model_event(1'b1, 1'b0, d);
      end else if (!m_f0) begin
        if (d == 8'hF0) m_f0 = 1'b1;
        else if (d != 8'hE0) begin
          model_event(1'b1, 1'b1, d);
          m_e0 = 1'b0;
        end
      end else begin
        model_event(1'b0, m_e0, d);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(bus_if.out_valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("out_ascii", 32'(bus_if.out_ascii), 32'(expq[0][7:0]));
      chk("out_mods", 32'(bus_if.out_mods), 32'(expq[0][9:8]));
    end
    chk("caps_lock", 32'(caps_lock), 32'(m_caps));
    chk("lang", 32'(lang), 32'(m_lang));
    chk("shift_eff", 32'(shift_eff), 32'(m_shift_eff()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
  endtask

  // One clock cycle: check, drive, model the edge, return on the falling edge
  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    check_outputs();
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.out_ready = rdy;
    @(posedge clk);
    cyc++;
    model_edge(v, d, rdy);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, rdy_g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy_g);
  endtask

  task automatic do_reset();
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_ascii", 32'(bus_if.out_ascii), 32'd0);
    chk("rst_out_mods", 32'(bus_if.out_mods), 32'd0);
    chk("rst_caps", 32'(caps_lock), 32'd0);
    chk("rst_lang", 32'(lang), 32'd0);
    chk("rst_shift_eff", 32'(shift_eff), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int         ovf_cnt;
    int         pops0;
    logic [7:0] burst [9];
    logic [7:0] pause_seq [8];
    logic [7:0] d;
    int         r;

    burst     = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single make of 'a'
    rdy_g = 1'b0;
    send(8'h1C);
    chk("t1_rom_addr", 32'(rom_addr), 32'h01C);
    idle(2);
    chk("t1_out_valid", 32'(bus_if.out_valid), 32'd1);
    chk("t1_out_ascii", 32'(bus_if.out_ascii), 32'h61);
    chk("t1_out_mods", 32'(bus_if.out_mods), 32'd0);
    rdy_g = 1'b1;
    idle(1);
    chk("t1_drained", 32'(bus_if.out_valid), 32'd0);

    // Shifted key with breaks
    pops0 = n_pops;
    send(8'h12);
    send(8'h1C);
    chk("t2_rom_addr", 32'(rom_addr), 32'h21C);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    idle(3);
    chk("t2_shift_eff", 32'(shift_eff), 32'd0);
    chk("t2_entries", 32'(n_pops - pops0), 32'd1);

    // Caps lock typematic repeats
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("t3_caps", 32'(caps_lock), 32'd1);
    send(8'h12);
    chk("t3_shift_caps", 32'(shift_eff), 32'd0);
    send(8'hF0); send(8'h12);
    chk("t3_caps_only", 32'(shift_eff), 32'd1);

    // Language layer wrap and right ctrl
    do_reset();
    rdy_g = 1'b0;
    send(LANG_KEY);
    send(LANG_KEY);
    chk("t4_lang1", 32'(lang), 32'd1);
    send(8'hF0); send(LANG_KEY);
    send(LANG_KEY);
    chk("t4_lang_wrap", 32'(lang), 32'd0);
    send(8'hF0); send(LANG_KEY);
    send(8'hE0); send(8'h14); send(8'h1C);
    idle(2);
    chk("t4_rctrl_mods", 32'(bus_if.out_mods), 32'b10);
    rdy_g = 1'b1; idle(1); rdy_g = 1'b0;
    send(8'hE0); send(8'hF0); send(8'h14); send(8'h1C);
    idle(2);
    chk("t4_rctrl_clear", 32'(bus_if.out_mods), 32'b00);
    rdy_g = 1'b1; idle(1);

    // Overflow with a stalled consumer
    do_reset();
    rdy_g = 1'b0;
    foreach (burst[i]) send(burst[i]);
    ovf_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0);
      ovf_cnt += int'(overflow);
    end
    chk("t5_ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("t5_out_valid", 32'(bus_if.out_valid), 32'd1);
    pops0 = n_pops;
    rdy_g = 1'b1;
    idle(10);
    chk("t5_kept", 32'(n_pops - pops0), 32'(FIFO_DEPTH));

    // Pause sequence swallowed, reset aborts a prefix
    do_reset();
    rdy_g = 1'b0;
    foreach (pause_seq[i]) send(pause_seq[i]);
    chk("t6_pause_silent", 32'(rom_addr), 32'd0);
    send(8'h1C);
    chk("t6_rom_addr", 32'(rom_addr), 32'h01C);
    idle(2);
    chk("t6_ascii", 32'(bus_if.out_ascii), 32'h61);
    chk("t6_mods", 32'(bus_if.out_mods), 32'd0);
    pops0 = n_pops;
    rdy_g = 1'b1;
    idle(3);
    chk("t6_entries", 32'(n_pops - pops0), 32'd1);
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("t6_reset_ext", 32'(rom_addr), 32'h01C);
    idle(3);

    // Randomized byte stream with bursty consumer
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      r = int'($urandom_range(0, 31));
      if (r <= 2)       d = 8'hE0;
      else if (r <= 5)  d = 8'hF0;
      else if (r == 6)  d = 8'hE1;
      else if (r <= 8)  d = 8'h12;
      else if (r == 9)  d = 8'h59;
      else if (r == 10) d = 8'h14;
      else if (r == 11) d = 8'h11;
      else if (r <= 13) d = 8'h58;
      else if (r == 14) d = LANG_KEY;
      else              d = 8'($urandom_range(0, 8'h7F));
      if (((i / 200) % 2) == 1) rdy_g = ($urandom_range(0, 3) == 0);
      else                      rdy_g = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, d, rdy_g);
    end
    rdy_g = 1'b1;
    idle(FIFO_DEPTH + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
